// File: rtl/sim_ctrl_pkg.sv
// ==========================================================================
// sim_ctrl_pkg : shared run-controller types and default constants. Rev 1.0
// ==========================================================================
`default_nettype none

package sim_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_PRE     = 3'd1,
    ST_ASSERT  = 3'd2,
    ST_RELEASE = 3'd3,
    ST_RUN     = 3'd4,
    ST_DRAIN   = 3'd5,
    ST_DONE    = 3'd6
  } run_state_t;

  localparam logic [31:0] DEF_MBOX_ADDR = 32'h0000_FFFC;
  localparam logic [31:0] DEF_PASS_CODE = 32'h0000_0001;

  // Condensed result encoding for software or LED readout.
  localparam logic [1:0] RES_NONE    = 2'd0;
  localparam logic [1:0] RES_PASS    = 2'd1;
  localparam logic [1:0] RES_FAIL    = 2'd2;
  localparam logic [1:0] RES_TIMEOUT = 2'd3;

endpackage

`default_nettype wire

// File: rtl/sim_run_ctrl_stagger_release.sv
// ==========================================================================
// stagger_release : per-channel staggered release of active-low core resets. Rev 1.0
// ==========================================================================
`default_nettype none

module stagger_release #(
  parameter int unsigned N_CH        = 1,
  parameter int unsigned STAGGER_CYC = 0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            rel_start,
  input  logic            hold_low,
  output logic [N_CH-1:0] core_resetn,
  output logic            rel_last
);

  localparam int unsigned REL_LAST = (N_CH - 1) * STAGGER_CYC;
  localparam int unsigned REL_W    = (REL_LAST > 0) ? $clog2(REL_LAST + 1) : 1;

  logic             active;
  logic [REL_W-1:0] rel_cnt;
  logic [N_CH-1:0]  rel_up;

  assign rel_last = active && (rel_cnt == REL_W'(REL_LAST));

  for (genvar k = 0; k < N_CH; k++) begin : g_ch
    if (k == 0) begin : g_first
      assign rel_up[k] = 1'b1;
    end else begin : g_rest
      assign rel_up[k] = (rel_cnt >= REL_W'(k * STAGGER_CYC));
    end
  end

  // Outputs lag the controlling state by one cycle so every pin is a flop.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      active      <= 1'b0;
      rel_cnt     <= '0;
      core_resetn <= '1;
    end else begin
      if (rel_start) begin
        active  <= 1'b1;
        rel_cnt <= '0;
      end else if (rel_last) begin
        active  <= 1'b0;
      end else if (active) begin
        rel_cnt <= rel_cnt + REL_W'(1);
      end

      if (hold_low) begin
        core_resetn <= '0;
      end else if (active) begin
        core_resetn <= rel_up;
      end else begin
        core_resetn <= '1;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/sim_run_ctrl.sv
// ==========================================================================
// sim_run_ctrl : core reset sequencing, run timing and mailbox/watchdog end-of-test. Rev 1.0
// ==========================================================================
`default_nettype none

module sim_run_ctrl
  import sim_ctrl_pkg::*;
#(
  parameter int unsigned       N_CH        = 1,
  parameter int unsigned       PRE_CYC     = 1,
  parameter int unsigned       ASSERT_CYC  = 2,
  parameter int unsigned       STAGGER_CYC = 0,
  parameter int unsigned       TIMEOUT_CYC = 100,
  parameter int unsigned       DRAIN_CYC   = 1,
  parameter int unsigned       ADDR_W      = 32,
  parameter int unsigned       DATA_W      = 32,
  parameter logic [ADDR_W-1:0] MBOX_ADDR   = ADDR_W'(DEF_MBOX_ADDR),
  parameter logic [DATA_W-1:0] PASS_CODE   = DATA_W'(DEF_PASS_CODE),
  parameter int unsigned       CNT_W       = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              dmem_we,
  input  logic [ADDR_W-1:0] dmem_addr,
  input  logic [DATA_W-1:0] dmem_wdata,
  output logic [N_CH-1:0]   core_resetn,
  output logic              running,
  output logic              done,
  output logic              pass,
  output logic              timeout,
  output logic [DATA_W-1:0] mbox_code,
  output logic [CNT_W-1:0]  cycle_count
);

  if (N_CH < 1) begin : g_chk_nch
    $error("sim_run_ctrl: N_CH must be at least 1");
  end
  if (ASSERT_CYC < 1) begin : g_chk_assert
    $error("sim_run_ctrl: ASSERT_CYC must be at least 1");
  end
  if ((CNT_W < 32) && (TIMEOUT_CYC >= (32'd1 << CNT_W))) begin : g_chk_timeout
    $error("sim_run_ctrl: TIMEOUT_CYC does not fit in CNT_W");
  end

  run_state_t  state;
  run_state_t  state_nx;
  logic [31:0] phase_cnt;
  logic        start_ok;
  logic        mbox_hit;
  logic        wd_hit;
  logic        rel_start;
  logic        rel_last;

  assign start_ok = start && ((state == ST_IDLE) || (state == ST_DONE));
  assign mbox_hit = (state == ST_RUN) && dmem_we && (dmem_addr == MBOX_ADDR);
  assign wd_hit   = (TIMEOUT_CYC != 0) && (state == ST_RUN) &&
                    (cycle_count == CNT_W'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx  = state;
    rel_start = 1'b0;
    case (state)
      ST_IDLE, ST_DONE: begin
        if (start) state_nx = ST_PRE;
      end
      ST_PRE: begin
        if ((phase_cnt + 32'd1) >= PRE_CYC) state_nx = ST_ASSERT;
      end
      ST_ASSERT: begin
        if ((phase_cnt + 32'd1) >= ASSERT_CYC) begin
          state_nx  = ST_RELEASE;
          rel_start = 1'b1;
        end
      end
      ST_RELEASE: begin
        if (rel_last) state_nx = ST_RUN;
      end
      ST_RUN: begin
        if (mbox_hit || wd_hit) state_nx = ST_DRAIN;
      end
      ST_DRAIN: begin
        if ((phase_cnt + 32'd1) >= DRAIN_CYC) state_nx = ST_DONE;
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  // Dwell counter for the fixed-length phases; restarts on every transition.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      phase_cnt <= '0;
    end else if (state_nx != state) begin
      phase_cnt <= '0;
    end else if (state inside {ST_PRE, ST_ASSERT, ST_DRAIN}) begin
      phase_cnt <= phase_cnt + 32'd1;
    end
  end

  stagger_release #(
    .N_CH        (N_CH),
    .STAGGER_CYC (STAGGER_CYC)
  ) u_stagger (
    .clk         (clk),
    .reset       (reset),
    .rel_start   (rel_start),
    .hold_low    (state == ST_ASSERT),
    .core_resetn (core_resetn),
    .rel_last    (rel_last)
  );

  // Mailbox has priority over the watchdog when both fire in one cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      running     <= 1'b0;
      done        <= 1'b0;
      pass        <= 1'b0;
      timeout     <= 1'b0;
      mbox_code   <= '0;
      cycle_count <= '0;
    end else begin
      running <= (state == ST_RUN);
      done    <= (state == ST_DONE);
      if (start_ok) begin
        pass        <= 1'b0;
        timeout     <= 1'b0;
        mbox_code   <= '0;
        cycle_count <= '0;
      end else if (state == ST_RUN) begin
        if (cycle_count != '1) begin
          cycle_count <= cycle_count + CNT_W'(1);
        end
        if (mbox_hit) begin
          mbox_code <= dmem_wdata;
          pass      <= (dmem_wdata == PASS_CODE);
        end else if (wd_hit) begin
          timeout <= 1'b1;
          pass    <= 1'b0;
        end
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_sim_run_ctrl.sv
// ==========================================================================
// tb_sim_run_ctrl : directed bench for sim_run_ctrl over three parameter sets. Rev 1.0
// ==========================================================================
`default_nettype none

module tb_sim_run_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start0 = 1'b0, start1 = 1'b0, start2 = 1'b0;
  logic        dmem_we = 1'b0;
  logic [31:0] dmem_addr = '0;
  logic [31:0] dmem_wdata = '0;

  logic [0:0]  rn0, rn1;
  logic [3:0]  rn2;
  logic        run0, done0, pass0, to0;
  logic        run1, done1, pass1, to1;
  logic        run2, done2, pass2, to2;
  logic [31:0] mbox0, mbox1, mbox2, cnt0, cnt1, cnt2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  sim_run_ctrl u_dut0 (
    .clk(clk), .reset(reset), .start(start0), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .core_resetn(rn0), .running(run0), .done(done0), .pass(pass0),
    .timeout(to0), .mbox_code(mbox0), .cycle_count(cnt0)
  );

  sim_run_ctrl #(.TIMEOUT_CYC(0)) u_dut1 (
    .clk(clk), .reset(reset), .start(start1), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .core_resetn(rn1), .running(run1), .done(done1), .pass(pass1),
    .timeout(to1), .mbox_code(mbox1), .cycle_count(cnt1)
  );

  sim_run_ctrl #(.N_CH(4), .STAGGER_CYC(3)) u_dut2 (
    .clk(clk), .reset(reset), .start(start2), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .core_resetn(rn2), .running(run2), .done(done2), .pass(pass2),
    .timeout(to2), .mbox_code(mbox2), .cycle_count(cnt2)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [31:0] addr, input logic [31:0] data);
    dmem_we    = 1'b1;
    dmem_addr  = addr;
    dmem_wdata = data;
  endtask

  task automatic bus_idle();
    dmem_we    = 1'b0;
    dmem_addr  = '0;
    dmem_wdata = '0;
  endtask

  // Leaves the bench 1 time unit after the edge that samples start.
  task automatic go(input int which);
    if (which == 0) start0 = 1'b1;
    if (which == 1) start1 = 1'b1;
    if (which == 2) start2 = 1'b1;
    tick();
    start0 = 1'b0;
    start1 = 1'b0;
    start2 = 1'b0;
  endtask

  // Default timing: low after edges t+2,t+3; running from t+5.
  task automatic bringup0(input string pfx);
    for (int e = 1; e <= 5; e++) begin
      tick();
      chk($sformatf("%s_rstn_t%0d", pfx, e), rn0, (e == 2 || e == 3) ? 1'b0 : 1'b1);
      chk($sformatf("%s_run_t%0d", pfx, e), run0, (e == 5) ? 1'b1 : 1'b0);
    end
    chk({pfx, "_cnt_t5"}, cnt0, 32'd1);
  endtask

  initial begin
    logic [3:0] exp_rn;

    tick(3);
    chk("rst_rstn", rn0, 1'b1);
    chk("rst_run", run0, 1'b0);
    chk("rst_done", done0, 1'b0);
    chk("rst_pass", pass0, 1'b0);
    chk("rst_to", to0, 1'b0);
    chk("rst_mbox", mbox0, 32'd0);
    chk("rst_cnt", cnt0, 32'd0);
    chk("rst_rstn4", rn2, 4'hF);
    reset = 1'b0;
    tick(6);
    chk("idle_rstn", rn0, 1'b1);

    // Pass code after 40 RUN cycles
    go(0);
    bringup0("t1");
    tick(38);
    chk("t1_cnt39", cnt0, 32'd39);
    wr(32'hFFFC, 32'h1);
    tick();
    bus_idle();
    tick();
    chk("t1_run_drop", run0, 1'b0);
    chk("t1_done_early", done0, 1'b0);
    tick();
    chk("t1_done", done0, 1'b1);
    chk("t1_pass", pass0, 1'b1);
    chk("t1_to", to0, 1'b0);
    chk("t1_mbox", mbox0, 32'h1);
    chk("t1_cnt", cnt0, 32'd40);

    // Fail code, restart from DONE, ignored writes in PRE/ASSERT/DRAIN/DONE
    go(0);
    wr(32'hFFFC, 32'h1);
    tick(2);
    bus_idle();
    chk("t2_pre_mbox", mbox0, 32'h0);
    chk("t2_pre_pass", pass0, 1'b0);
    chk("t2_done_clr", done0, 1'b0);
    tick(3);
    chk("t2_run", run0, 1'b1);
    wr(32'hFFF8, 32'h1);
    tick();
    bus_idle();
    chk("t2_wrongaddr_run", run0, 1'b1);
    chk("t2_cnt2", cnt0, 32'd2);
    tick(4);
    wr(32'hFFFC, 32'hDEAD);
    tick();
    wr(32'hFFFC, 32'h1);
    tick();
    bus_idle();
    tick();
    chk("t2_done", done0, 1'b1);
    chk("t2_pass", pass0, 1'b0);
    chk("t2_to", to0, 1'b0);
    chk("t2_mbox", mbox0, 32'hDEAD);
    chk("t2_cnt", cnt0, 32'd7);
    wr(32'hFFFC, 32'h1);
    tick(2);
    bus_idle();
    chk("t2_donewr_mbox", mbox0, 32'hDEAD);
    chk("t2_donewr_pass", pass0, 1'b0);
    chk("t2_donewr_done", done0, 1'b1);

    // Watchdog expiry
    go(0);
    tick(103);
    chk("t3_cnt99", cnt0, 32'd99);
    chk("t3_run", run0, 1'b1);
    tick(2);
    chk("t3_run_drop", run0, 1'b0);
    tick();
    chk("t3_done", done0, 1'b1);
    chk("t3_to", to0, 1'b1);
    chk("t3_pass", pass0, 1'b0);
    chk("t3_cnt", cnt0, 32'd100);

    // Mailbox in the watchdog's final cycle wins
    go(0);
    tick(103);
    wr(32'hFFFC, 32'h1);
    tick();
    bus_idle();
    tick(2);
    chk("t5_done", done0, 1'b1);
    chk("t5_pass", pass0, 1'b1);
    chk("t5_to", to0, 1'b0);
    chk("t5_mbox", mbox0, 32'h1);
    chk("t5_cnt", cnt0, 32'd100);

    // Asynchronous abort mid-ASSERT
    go(0);
    tick(2);
    chk("t6_rstn_low", rn0, 1'b0);
    #2 reset = 1'b1;
    #1;
    chk("t6_async_rstn", rn0, 1'b1);
    chk("t6_async_run", run0, 1'b0);
    chk("t6_async_done", done0, 1'b0);
    chk("t6_async_cnt", cnt0, 32'd0);
    #2 reset = 1'b0;
    tick(2);
    chk("t6_idle_rstn", rn0, 1'b1);
    go(0);
    bringup0("t6");
    wr(32'hFFFC, 32'h5);
    tick();
    bus_idle();
    tick(2);
    chk("t6_done", done0, 1'b1);
    chk("t6_pass", pass0, 1'b0);
    chk("t6_mbox", mbox0, 32'h5);
    chk("t6_cnt", cnt0, 32'd2);

    // Four channels, stagger 3
    go(2);
    for (int e = 1; e <= 14; e++) begin
      tick();
      exp_rn = 4'hF;
      if (e == 2 || e == 3) exp_rn = 4'h0;
      if (e >= 4 && e <= 13) begin
        for (int k = 0; k < 4; k++) exp_rn[k] = ((e - 4) >= 3 * k);
      end
      chk($sformatf("t4_rstn_t%0d", e), rn2, exp_rn);
      chk($sformatf("t4_run_t%0d", e), run2, (e == 14) ? 1'b1 : 1'b0);
    end

    // Watchdog disabled: still running after 1000 cycles
    go(1);
    tick(1000);
    chk("t7_run", run1, 1'b1);
    chk("t7_done", done1, 1'b0);
    chk("t7_to", to1, 1'b0);
    chk("t7_cnt", cnt1, 32'd996);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/sim_run_ctrl.md
# sim_run_ctrl

Parametrised run controller for CPU bring-up benches and FPGA self-test. It sequences per-channel active-low core resets and times the run with a cycle counter. It detects end-of-test from a data-memory mailbox write or a watchdog timeout, and reports pass/fail after a drain interval. It sits beside `cpu` and snoops the data-memory write port; it replaces fixed-length reset/run sequencing with a reusable synthesizable block.

## Interface
Parameters:
- `N_CH`, 1: number of independent core reset outputs.
- `PRE_CYC`, 1: cycles outputs stay deasserted (high) after start, before assertion.
- `ASSERT_CYC`, 2: cycles every `core_resetn` is held low.
- `STAGGER_CYC`, 0: cycles between successive channel releases (channel 0 first).
- `TIMEOUT_CYC`, 100: watchdog limit in RUN cycles; 0 disables the watchdog.
- `DRAIN_CYC`, 1: cycles spent in DRAIN before DONE.
- `ADDR_W`, 32: data-memory address width.
- `DATA_W`, 32: data-memory data width.
- `MBOX_ADDR`, 32'hFFFC: mailbox word address.
- `PASS_CODE`, 32'h1: mailbox value meaning pass.
- `CNT_W`, 32: cycle counter width.

Ports:
- `clk`, in, 1: clock.
- `reset`, in, 1: asynchronous, active-high reset of this block.
- `start`, in, 1: one-cycle pulse that begins a sequence; honoured only in IDLE or DONE.
- `dmem_we`, in, 1: data-memory write strobe.
- `dmem_addr`, in, `ADDR_W`: write address.
- `dmem_wdata`, in, `DATA_W`: write data.
- `core_resetn`, out, `N_CH`: active-low reset per core channel.
- `running`, out, 1: high in RUN.
- `done`, out, 1: high in DONE.
- `pass`, out, 1: valid while `done`.
- `timeout`, out, 1: valid while `done`.
- `mbox_code`, out, `DATA_W`: last mailbox value captured.
- `cycle_count`, out, `CNT_W`: RUN cycles elapsed.

## Operation
- FSM states: IDLE, PRE, ASSERT, RELEASE, RUN, DRAIN, DONE.
- IDLE → PRE on `start`. The counter, `cycle_count`, `mbox_code` and the sticky flags all clear on that edge.
- PRE: `core_resetn` stays all-ones for `PRE_CYC` cycles, then the FSM moves to ASSERT.
- ASSERT: `core_resetn` is all-zeros for `ASSERT_CYC` cycles, then the FSM moves to RELEASE.
- RELEASE: channel k rises at release-cycle k·`STAGGER_CYC`. After channel `N_CH-1` rises, the FSM moves to RUN. With `STAGGER_CYC`=0, all channels rise together and RELEASE lasts 1 cycle.
- RUN: `cycle_count` increments every cycle and saturates at all-ones.
- Mailbox hit in RUN: `dmem_we` with `dmem_addr==MBOX_ADDR`. The block captures `dmem_wdata` into `mbox_code`, sets `pass` = (`dmem_wdata==PASS_CODE`), and moves to DRAIN.
- Watchdog in RUN: when `TIMEOUT_CYC`≠0 and `cycle_count` reaches `TIMEOUT_CYC-1`, the block sets `timeout`=1 and `pass`=0, then moves to DRAIN.
- Simultaneous mailbox hit and watchdog expiry: the mailbox wins and `timeout` stays 0.
- DRAIN: lasts `DRAIN_CYC` cycles. `core_resetn` stays high and writes are ignored. The FSM then moves to DONE.
- DONE: results hold until the next `start`. A `start` here re-runs from PRE.
- `start` in any other state is ignored.
- Mailbox writes outside RUN are ignored.

## Timing
- Reset values: `core_resetn`=all-ones, `running`=0, `done`=0, `pass`=0, `timeout`=0, `mbox_code`=0, `cycle_count`=0, state=IDLE.
- Mid-sequence `reset` aborts immediately. `core_resetn` goes all-ones asynchronously, which does not glitch low.
- All outputs are registered.
- `start` at edge t gives `core_resetn` low from edge t+`PRE_CYC`+1 through edge t+`PRE_CYC`+`ASSERT_CYC`.
- `running` rises the cycle after the last channel releases.
- Mailbox hit at edge t: `running` drops at t+1, `done`/`pass`/`mbox_code` are valid at t+1+`DRAIN_CYC`.
- `cycle_count` freezes on leaving RUN.

## Structure
- Shared package `sim_ctrl_pkg`:
  - state enum `run_state_t`.
  - default `MBOX_ADDR`/`PASS_CODE` constants.
  - result-code constants.
- One sub-module, `stagger_release`: per-channel release counter driving `core_resetn` from a single release-start pulse.
- Parameters are checked at elaboration: `N_CH`≥1, `ASSERT_CYC`≥1, `TIMEOUT_CYC` fits in `CNT_W`.

## Test plan
- Defaults, `start` at cycle 10 → `core_resetn` low for exactly 2 cycles, then `running`=1. Write 1 to 0xFFFC after 40 RUN cycles → `done`=1, `pass`=1, `mbox_code`=1, `cycle_count`=40.
- Write 0xDEAD to the mailbox → `pass`=0, `timeout`=0, `mbox_code`=0xDEAD.
- No mailbox write with `TIMEOUT_CYC`=100 → `timeout`=1, `pass`=0, `cycle_count`=100. With `TIMEOUT_CYC`=0 the run never ends in 1000 cycles.
- `N_CH`=4, `STAGGER_CYC`=3 → channels rise at RELEASE offsets 0/3/6/9, and `running` follows one cycle after channel 3.
- Mailbox write in the watchdog's final cycle → `pass` per data, `timeout`=0. Writes in PRE/ASSERT/DRAIN/DONE → no effect.
- Assert `reset` mid-ASSERT → outputs return to their reset values without waiting for a clock edge. `start` after release → full sequence repeats with cleared counters.
